// File: rtl/perf_cnt_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_cnt_pkg;

  typedef enum logic {ST_RUN, ST_HALTED} perf_st_e;

  localparam int CH_CYCLE  = 0;
  localparam int CH_BRANCH = 1;
  localparam int CH_JUMP   = 2;
  localparam int PERF_W    = 32;

endpackage

// File: rtl/perf_cnt_channel.sv
// One event counter with shadow capture and sticky overflow.
// Build option PERF_CNT_SAT_EN: saturate at all-ones instead of wrapping.
import perf_cnt_pkg::*;

module perf_cnt_channel #(
  parameter int WIDTH = PERF_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             freeze,
  input  logic             snap,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] shadow,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;
  logic             inc_en;

  always_comb begin
    inc_en  = inc & ~freeze;
    count_d = count_q;
    ovf_d   = ovf_q;
`ifdef PERF_CNT_SAT_EN
    if (inc_en && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
      if (&count_d) ovf_d = 1'b1;
    end
`else
    if (inc_en) begin
      count_d = count_q + WIDTH'(1);
      if (&count_q) ovf_d = 1'b1;
    end
`endif
    // Snapshot sees the post-increment value so the same-cycle event is kept.
    shadow_d = snap ? count_d : shadow_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q  <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count  = count_q;
  assign shadow = shadow_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with halt FSM, snapshot and registered read port.
// Build option PERF_CNT_SAT_EN selects saturating counters (see perf_cnt_channel).
import perf_cnt_pkg::*;

module perf_counter_bank #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = PERF_W,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              halt_req,
  input  logic              snap,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              halted
);

  perf_st_e state_q, state_d;
  logic     freeze;

  logic [NUM_CH-1:0][WIDTH-1:0] count_w;
  logic [NUM_CH-1:0][WIDTH-1:0] shadow_w;
  logic [WIDTH-1:0]             rd_data_q, rd_data_d;

  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    case (state_q)
      ST_RUN:     if (halt_req) state_d = ST_HALTED;
      ST_HALTED:  freeze = 1'b1;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_cnt_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .clr    (clr),
      .inc    (event_in[i]),
      .freeze (freeze),
      .snap   (snap),
      .count  (count_w[i]),
      .shadow (shadow_w[i]),
      .ovf    (ovf[i])
    );
  end

  // Compare-based mux: selects past NUM_CH fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data_d = shadow_w[i];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
  assign halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank (NUM_CH=3, WIDTH=8); honours PERF_CNT_SAT_EN.
module tb_perf_counter_bank;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;
  localparam int SEL_W  = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic [NUM_CH-1:0] event_in;
  logic              halt_req;
  logic              snap;
  logic [SEL_W-1:0]  rd_sel;
  logic [WIDTH-1:0]  rd_data;
  logic [NUM_CH-1:0] ovf;
  logic              halted;

  int n_chk  = 0;
  int n_pass = 0;

  perf_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .clr      (clr),
    .event_in (event_in),
    .halt_req (halt_req),
    .snap     (snap),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .ovf      (ovf),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic take_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic rd(input logic [SEL_W-1:0] sel, input logic [31:0] exp, input string tag);
    rd_sel = sel;
    tick();
    chk(tag, 32'(rd_data), exp);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  logic [31:0] exp_a, exp_b;

  initial begin
    clr = 1'b1; event_in = '0; halt_req = 1'b0; snap = 1'b0; rd_sel = '0;
    tick(2);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_rd", 32'(rd_data), 0);
    clr = 1'b0;

    // basic count: channel 0 only
    event_in = 3'b001;
    tick(10);
    event_in = '0;
    take_snap();
    rd(0, 10, "basic_ch0");
    rd(1, 0, "basic_ch1");
    rd(2, 0, "basic_ch2");
    chk("basic_ovf", 32'(ovf), 0);

    // snapshot includes same-cycle increment; out-of-range select
    do_clr();
    event_in = 3'b001;
    tick(4);
    snap = 1'b1;
    tick();
    snap = 1'b0; event_in = '0;
    rd(0, 5, "snap_same_cycle");
    rd(7, 0, "rd_sel_oob");

    // halt freeze
    do_clr();
    event_in = 3'b111;
    tick(5);
    chk("pre_halt", 32'(halted), 0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halted_set", 32'(halted), 1);
    tick(20);
    halt_req = 1'b1;
    tick(2);
    halt_req = 1'b0;
    take_snap();
    rd(0, 6, "halt_ch0");
    rd(1, 6, "halt_ch1");
    rd(2, 6, "halt_ch2");
    chk("halted_stays", 32'(halted), 1);
    event_in = '0;

    // wrap / saturate on channel 0
    do_clr();
    event_in = 3'b001;
    tick(255);
`ifdef PERF_CNT_SAT_EN
    exp_a = 1; exp_b = 255;
`else
    exp_a = 0; exp_b = 0;
`endif
    chk("ovf_at_255", 32'(ovf), exp_a);
    tick();
    chk("ovf_at_256", 32'(ovf), 1);
    event_in = '0;
    take_snap();
    rd(0, exp_b, "cnt_at_256");
    event_in = 3'b001;
    tick(44);
    event_in = '0;
`ifdef PERF_CNT_SAT_EN
    exp_b = 255;
`else
    exp_b = 44;
`endif
    chk("ovf_sticky", 32'(ovf), 1);
    take_snap();
    rd(0, exp_b, "cnt_at_300");

    // clr beats snap/halt/events in the same cycle
    halt_req = 1'b1;
    tick();
    chk("prio_pre_halt", 32'(halted), 1);
    clr = 1'b1; snap = 1'b1; event_in = 3'b111;
    tick();
    clr = 1'b0; snap = 1'b0; halt_req = 1'b0; event_in = '0;
    chk("prio_halted", 32'(halted), 0);
    chk("prio_ovf", 32'(ovf), 0);
    chk("prio_rd", 32'(rd_data), 0);
    rd(0, 0, "prio_shadow");
    take_snap();
    rd(0, 0, "prio_count");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
